exec_stage: RTL
===============

Name: exec_stage

Overview:
- Execute stage of the 5-stage MIPS pipeline.
- Consumes the ID-stage pipeline registers: operand A, operand B, control word and sign-extended immediate.
- Performs single-cycle ALU operations and multi-cycle unsigned multiply/divide into HI/LO.
- Registers results into the EX/MEM pipeline registers and drives a stall back to IF/ID while a mul/div is in progress.

Parameters:
- WIDTH, 32, datapath width.
- MD_CYCLES, 32, iterations of the multiply/divide engine; must equal WIDTH.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  asynchronous, active-high reset.
- id_regA  in  32  operand A (rs value) from the ID stage.
- id_regB  in  32  operand B (rt value) from the ID stage.
- id_regCTRL  in  32  control word from the ID stage.
- id_regIMM  in  32  sign-extended immediate from the ID stage.
- stall  out  1  high while the mul/div engine is busy; IF/ID hold their registers.
- ex_alu_out  out  32  registered ALU result or memory address.
- ex_store_data  out  32  registered operand B, used as store data.
- ex_ctrl  out  32  registered control word passed to MEM/WB; zero means bubble.
- ex_zero  out  1  registered flag, high when the ALU result equals 0.
- hi_out  out  32  HI register.
- lo_out  out  32  LO register.

Behaviour:
- Control word fields:
  - [3:0] alu_op.
  - [4] alu_src: B operand is imm when 1, regB when 0.
  - [5] mem_write.
  - [6] mem_read.
  - [7] reg_write.
  - [12:8] destination register.
  - [13] md_start.
  - [14] md_div: 1 = DIVU, 0 = MULTU.
  - [15] valid.
  - [31:16] reserved, passed through unchanged.
- alu_op encodings:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR.
  - 6 SLT (signed), 7 SLTU.
  - 8 SLL, 9 SRL, 10 SRA; shift amount is imm[10:6], shifted operand is regB.
  - 11 LUI: result = {imm[15:0], 16'h0}.
  - 12 MFHI, 13 MFLO.
  - 14–15 yield 0.
- Arithmetic is modulo 2^32; there is no overflow trap.
- Reset: all outputs, HI, LO and FSM state go to 0; FSM enters IDLE.
- Non-mul/div instruction (valid=1, md_start=0): latency 1. On the next rising edge:
  - ex_alu_out = result, ex_store_data = regB, ex_ctrl = id_regCTRL, ex_zero = (result == 0).
- valid=0: the instruction is a bubble. Register ex_ctrl = 0; the other outputs may take any value.
- FSM states:
  - IDLE → MUL or DIV when valid && md_start is sampled.
  - MUL / DIV → DONE after MD_CYCLES iterations.
  - DONE → IDLE after one cycle.
- Mul/div issue cycle:
  - Latch regA and regB into the engine and clear the iteration counter.
  - ex_ctrl takes the mul/div control word with reg_write forced to 0.
  - stall rises combinationally in the same cycle as the start is sampled.
- stall is asserted in MUL, DIV, and during the issue cycle.
- stall is deasserted in DONE and IDLE.
- While stalled, id_* inputs are ignored and ex_ctrl = 0 each cycle (bubbles).
- MUL: shift-add, one bit per cycle. In DONE, {HI, LO} = 64-bit unsigned product.
- DIV: restoring division, one bit per cycle. In DONE, LO = quotient and HI = remainder.
- Divide by zero: LO = 32'hFFFFFFFF, HI = dividend. Still takes the full MD_CYCLES; no exception.
- HI/LO update only on the DONE edge.
- Total stall = MD_CYCLES+1 cycles from the issue edge. The instruction held in ID is accepted in the DONE cycle.
- MFHI/MFLO issued immediately after mul/div complete see the new HI/LO, because the stall guarantees ordering.
- md_start together with valid=0 is ignored.
- Reset mid-operation aborts the engine, clears HI/LO and drops stall asynchronously.

Decomposition:
- Shared package exec_pkg contains:
  - alu_op localparams.
  - Control-word bit positions and field widths.
  - FSM state encoding.
  - MD_CYCLES default.
- Sub-module muldiv_unit (clk, rst, start, div, a, b, busy, done, hi, lo) holds the FSM and iterative engine.
- exec_stage holds the ALU mux and the EX/MEM registers.

Test Plan:
- ADD: regA=5, regB=7, alu_src=0, valid=1 → next cycle ex_alu_out=12, ex_zero=0, ex_ctrl=input word.
- SUB with imm: regA=3, imm=3, alu_src=1 → ex_alu_out=0, ex_zero=1. SLT: regA=0xFFFFFFFF, regB=1 → 1. SLTU with the same operands → 0.
- MULTU: 0xFFFFFFFF × 2 →
  - stall high for 33 cycles.
  - HI=1, LO=0xFFFFFFFE.
  - A following MFHI returns 1.
- DIVU: 100 / 7 → LO=14, HI=2. DIVU: 9 / 0 → LO=0xFFFFFFFF, HI=9. Each completes in 33 stall cycles.
- Bubble/stall: an ADD presented during MUL is ignored, and ex_ctrl=0 every stalled cycle. When held and re-presented after DONE, it executes once.
- Reset asserted asynchronously at iteration 10 of DIV → stall=0, HI=LO=0, ex_ctrl=0 immediately; the next ADD executes normally.

Source files
------------

// File: rtl/exec_pkg.sv
// Shared definitions for the MIPS execute stage: ALU opcodes, control-word
// field positions, mul/div FSM encoding and engine defaults.
package exec_pkg;

    // Default iteration count of the mul/div engine (one bit per cycle).
    localparam int MD_CYCLES_DEFAULT = 32;

    // Control-word layout.
    localparam int CTRL_W          = 32;
    localparam int CTRL_ALU_OP_LSB = 0;
    localparam int CTRL_ALU_OP_W   = 4;
    localparam int CTRL_ALU_SRC    = 4;
    localparam int CTRL_MEM_WRITE  = 5;
    localparam int CTRL_MEM_READ   = 6;
    localparam int CTRL_REG_WRITE  = 7;
    localparam int CTRL_DEST_LSB   = 8;
    localparam int CTRL_DEST_W     = 5;
    localparam int CTRL_MD_START   = 13;
    localparam int CTRL_MD_DIV     = 14;
    localparam int CTRL_VALID      = 15;
    localparam int CTRL_RSVD_LSB   = 16;
    localparam int CTRL_RSVD_W     = 16;

    // ALU opcodes.
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_NOR  = 4'd5;
    localparam logic [3:0] ALU_SLT  = 4'd6;
    localparam logic [3:0] ALU_SLTU = 4'd7;
    localparam logic [3:0] ALU_SLL  = 4'd8;
    localparam logic [3:0] ALU_SRL  = 4'd9;
    localparam logic [3:0] ALU_SRA  = 4'd10;
    localparam logic [3:0] ALU_LUI  = 4'd11;
    localparam logic [3:0] ALU_MFHI = 4'd12;
    localparam logic [3:0] ALU_MFLO = 4'd13;

    // Mul/div FSM encoding.
    localparam logic [1:0] MD_IDLE = 2'd0;
    localparam logic [1:0] MD_MUL  = 2'd1;
    localparam logic [1:0] MD_DIV  = 2'd2;
    localparam logic [1:0] MD_DONE = 2'd3;

    // Extract the ALU opcode from a control word.
    function automatic logic [3:0] aluOpOf(input logic [CTRL_W-1:0] ctrl);
        return ctrl[CTRL_ALU_OP_LSB +: CTRL_ALU_OP_W];
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative unsigned multiply (shift-add) / divide (restoring) engine with
// its sequencing FSM. One result bit per cycle; HI/LO are written on the
// edge that enters DONE so they are already valid during the DONE cycle.
module muldiv_unit
    import exec_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int MD_CYCLES = MD_CYCLES_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(MD_CYCLES);

    logic [1:0]         state;
    logic [CNT_W-1:0]   count;
    // Upper half: partial product / partial remainder.
    // Lower half: multiplier being consumed / dividend turning into quotient.
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] accNext;
    logic [WIDTH-1:0]   operand;
    logic [WIDTH:0]     mulSum;
    logic [WIDTH:0]     divShift;
    logic [WIDTH:0]     divDiff;
    logic               lastIter;

    assign busy     = (state == MD_MUL) || (state == MD_DIV);
    assign done     = (state == MD_DONE);
    assign lastIter = (count == CNT_W'(MD_CYCLES - 1));

    // One engine iteration for whichever operation is running.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        accNext  = acc;
        mulSum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
        divShift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        divDiff  = divShift - {1'b0, operand};
        if (state == MD_MUL) begin
            accNext = {mulSum, acc[WIDTH-1:1]};
        end else if (state == MD_DIV) begin
            // No borrow means the divisor fits: keep the difference, quotient bit 1.
            // A zero divisor never borrows, giving all-ones quotient and remainder = dividend.
            if (!divDiff[WIDTH]) begin
                accNext = {divDiff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            end else begin
                accNext = {divShift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            end
        end
    end

    // FSM, iteration counter, engine state and HI/LO.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            state   <= MD_IDLE;
            count   <= '0;
            acc     <= '0;
            operand <= '0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            case (state)
                MD_IDLE, MD_DONE: begin
                    // DONE also accepts a new start so a back-to-back mul/div is not lost.
                    if (start) begin
                        state   <= div ? MD_DIV : MD_MUL;
                        count   <= '0;
                        acc     <= {{WIDTH{1'b0}}, a};
                        operand <= b;
                    end else begin
                        state <= MD_IDLE;
                    end
                end
                MD_MUL, MD_DIV: begin
                    acc   <= accNext;
                    count <= count + CNT_W'(1);
                    if (lastIter) begin
                        state <= MD_DONE;
                        hi    <= accNext[2*WIDTH-1:WIDTH];
                        lo    <= accNext[WIDTH-1:0];
                    end
                end
                default: state <= MD_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/exec_stage.sv
// Execute stage of the 5-stage MIPS pipeline: ALU result mux, EX/MEM
// pipeline registers and the mul/div engine with its stall back to IF/ID.
module exec_stage
    import exec_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int MD_CYCLES = MD_CYCLES_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  id_regA,
    input  logic [WIDTH-1:0]  id_regB,
    input  logic [CTRL_W-1:0] id_regCTRL,
    input  logic [WIDTH-1:0]  id_regIMM,
    output logic              stall,
    output logic [WIDTH-1:0]  ex_alu_out,
    output logic [WIDTH-1:0]  ex_store_data,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic              ex_zero,
    output logic [WIDTH-1:0]  hi_out,
    output logic [WIDTH-1:0]  lo_out
);

    localparam logic [CTRL_W-1:0] REG_WRITE_MASK = CTRL_W'(1) << CTRL_REG_WRITE;

    logic [3:0]        aluOp;
    logic              aluSrc;
    logic              mdStart;
    logic              mdDiv;
    logic              valid;
    logic [4:0]        shamt;
    logic [WIDTH-1:0]  opA;
    logic [WIDTH-1:0]  opB;
    logic [WIDTH-1:0]  aluResult;
    logic              mdBusy;
    logic              mdDone;
    logic              mdIssue;
    logic [CTRL_W-1:0] issueCtrl;

    assign aluOp   = aluOpOf(id_regCTRL);
    assign aluSrc  = id_regCTRL[CTRL_ALU_SRC];
    assign mdStart = id_regCTRL[CTRL_MD_START];
    assign mdDiv   = id_regCTRL[CTRL_MD_DIV];
    assign valid   = id_regCTRL[CTRL_VALID];
    assign shamt   = id_regIMM[10:6];
    assign opA     = id_regA;
    assign opB     = aluSrc ? id_regIMM : id_regB;

    // The mul/div writes HI/LO, never a GPR, so its reg_write is dropped downstream.
    assign issueCtrl = id_regCTRL & ~REG_WRITE_MASK;

    // Reset gates the issue term so stall drops immediately on an asynchronous reset.
    assign mdIssue = !rst && valid && mdStart && !mdBusy;
    assign stall   = mdBusy || mdIssue;

    muldiv_unit #(
        .WIDTH     (WIDTH),
        .MD_CYCLES (MD_CYCLES)
    ) u_muldiv (
        .clk   (clk),
        .rst   (rst),
        .start (mdIssue),
        .div   (mdDiv),
        .a     (id_regA),
        .b     (id_regB),
        .busy  (mdBusy),
        .done  (mdDone),
        .hi    (hi_out),
        .lo    (lo_out)
    );

    // Engine sanity: the completion cycle is never also a busy cycle.
    always_comb begin
        assert (!(mdDone && mdBusy));
    end

    // Single-cycle ALU result selection.
    always_comb begin
        aluResult = '0;
        case (aluOp)
            ALU_ADD:  aluResult = opA + opB;
            ALU_SUB:  aluResult = opA - opB;
            ALU_AND:  aluResult = opA & opB;
            ALU_OR:   aluResult = opA | opB;
            ALU_XOR:  aluResult = opA ^ opB;
            ALU_NOR:  aluResult = ~(opA | opB);
            ALU_SLT:  aluResult = {{(WIDTH-1){1'b0}}, ($signed(opA) < $signed(opB))};
            ALU_SLTU: aluResult = {{(WIDTH-1){1'b0}}, (opA < opB)};
            ALU_SLL:  aluResult = id_regB << shamt;
            ALU_SRL:  aluResult = id_regB >> shamt;
            ALU_SRA:  aluResult = $signed(id_regB) >>> shamt;
            ALU_LUI:  aluResult = {id_regIMM[15:0], {(WIDTH-16){1'b0}}};
            ALU_MFHI: aluResult = hi_out;
            ALU_MFLO: aluResult = lo_out;
            default:  aluResult = '0;
        endcase
    end

    // EX/MEM pipeline registers; bubbles (stalled or invalid) carry a zero control word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_alu_out    <= '0;
            ex_store_data <= '0;
            ex_ctrl       <= '0;
            ex_zero       <= 1'b0;
        end else if (mdBusy || !valid) begin
            ex_ctrl <= '0;
        end else begin
            ex_alu_out    <= aluResult;
            ex_store_data <= id_regB;
            ex_zero       <= (aluResult == '0);
            ex_ctrl       <= mdStart ? issueCtrl : id_regCTRL;
        end
    end

endmodule
